// File: rtl/cu_alu_pipe_if.sv
// Handshake/decode bundle between the issue stage (master) and the ALU-stage control unit (slave).
interface cu_alu_pipe_if #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned REG_W  = 2,
    parameter int unsigned CTRL_W = 4
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [OP_W-1:0]   op_code;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic              int_req;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] ALU_CONTROL;
    logic              SE2;
    logic [1:0]        SE3;
    logic              int_busy;
    logic              int_ack;

    modport master (
        output stall, flush, in_valid, op_code, ra, rb, int_req,
        input  in_ready, out_valid, ALU_CONTROL, SE2, SE3, int_busy, int_ack
    );

    modport slave (
        input  stall, flush, in_valid, op_code, ra, rb, int_req,
        output in_ready, out_valid, ALU_CONTROL, SE2, SE3, int_busy, int_ack
    );
endinterface

// File: rtl/cu_alu_pipe.sv
// Registered ALU-stage control decode with stall/flush and an interrupt-injection FSM
// that inserts INT_CYCLES forced "pass R[ra]" words.
module cu_alu_pipe #(
    parameter int unsigned OP_W       = 4,
    parameter int unsigned REG_W      = 2,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned INT_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    cu_alu_pipe_if.slave bus
);
    typedef enum logic {StRun, StIntSeq} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              se2_q, se2_d;
    logic [1:0]        se3_q, se3_d;
    logic              ack_q, ack_d;

    logic [OP_W-1:0]   op_hi;
    logic [3:0]        dec_ctrl;
    logic              dec_se2;
    logic [1:0]        dec_se3;
    logic [1:0]        sel;
    logic              accept;
    logic              unused_fields;

    assign op_hi         = bus.op_code >> 4;
    assign sel           = bus.ra[1:0];
    assign unused_fields = ^{bus.rb, bus.ra};

    always_comb begin
        dec_ctrl = 4'd0;
        dec_se2  = 1'b0;
        dec_se3  = 2'd0;
        if (op_hi == '0) begin
            case (bus.op_code[3:0])
                4'h1: begin
                    dec_ctrl = 4'd1;
                    dec_se3  = 2'd2;
                end
                4'h2, 4'h3, 4'h4, 4'h5: begin
                    dec_ctrl = bus.op_code[3:0];
                    dec_se2  = 1'b1;
                end
                4'h6: begin
                    dec_ctrl = 4'd6 + {2'b00, sel};
                    dec_se2  = ~sel[1];
                end
                4'h7: begin
                    unique case (sel)
                        2'd0: dec_se3  = 2'd1;
                        2'd1: dec_ctrl = 4'd2;
                        2'd2: dec_se3  = 2'd2;
                        2'd3: ;
                    endcase
                end
                4'h8: begin
                    dec_ctrl = 4'd10 + {2'b00, sel};
                    dec_se2  = 1'b1;
                end
                4'hA: dec_ctrl = 4'd3;
                4'hB: begin
                    if (sel == 2'd1) dec_se3 = 2'd1;
                    else if (sel[1]) dec_ctrl = 4'd2;
                end
                4'hC, 4'hD, 4'hE: dec_se3 = 2'd1;
                default: ;
            endcase
        end
    end

    assign accept = bus.in_valid & ~bus.flush;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q | bus.int_req;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        se2_d       = se2_q;
        se3_d       = se3_q;
        ack_d       = ack_q;
        if (!bus.stall) begin
            unique case (state_q)
                StRun: begin
                    out_valid_d = accept;
                    ctrl_d      = accept ? CTRL_W'(dec_ctrl) : '0;
                    se2_d       = accept & dec_se2;
                    se3_d       = accept ? dec_se3 : 2'd0;
                    ack_d       = 1'b0;
                    if (pend_q | bus.int_req) begin
                        state_d = StIntSeq;
                        cnt_d   = 4'(INT_CYCLES - 1);
                        // The request being serviced is consumed; only a second one stays pending.
                        pend_d  = pend_q & bus.int_req;
                    end
                end
                StIntSeq: begin
                    out_valid_d = 1'b1;
                    ctrl_d      = '0;
                    se2_d       = 1'b0;
                    se3_d       = 2'd1;
                    ack_d       = (cnt_q == 4'd0);
                    if (cnt_q == 4'd0) state_d = StRun;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            se2_q       <= 1'b0;
            se3_q       <= 2'd0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            se2_q       <= se2_d;
            se3_q       <= se3_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.in_ready    = ~bus.stall & (state_q == StRun);
    assign bus.int_busy    = (state_q == StIntSeq);
    assign bus.out_valid   = out_valid_q;
    assign bus.ALU_CONTROL = ctrl_q;
    assign bus.SE2         = se2_q;
    assign bus.SE3         = se3_q;
    assign bus.int_ack     = ack_q;
endmodule

// File: tb/tb_cu_alu_pipe.sv
// Scoreboard bench for cu_alu_pipe: a cycle model pushes expected output words, the sampled
// DUT outputs are popped against them one cycle later.
module tb_cu_alu_pipe;
    localparam int unsigned IntCycles = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cu_alu_pipe_if #(.OP_W(4), .REG_W(2), .CTRL_W(4)) bus ();

    cu_alu_pipe #(.OP_W(4), .REG_W(2), .CTRL_W(4), .INT_CYCLES(IntCycles)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ack_seen = 0;

    // Model state; output word is {valid, ctrl[3:0], se2, se3[1:0], ack}
    bit         m_int;
    int         m_cnt;
    bit         m_pend;
    logic [8:0] m_out;
    logic [9:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected {ctrl, se2, se3}; written as an explicit table per opcode/ra.
    function automatic logic [6:0] ref_dec(input logic [3:0] op, input logic [1:0] r);
        case ({op, r})
            6'h04, 6'h05, 6'h06, 6'h07: return {4'd1, 1'b0, 2'd2};
            6'h08, 6'h09, 6'h0A, 6'h0B: return {4'd2, 1'b1, 2'd0};
            6'h0C, 6'h0D, 6'h0E, 6'h0F: return {4'd3, 1'b1, 2'd0};
            6'h10, 6'h11, 6'h12, 6'h13: return {4'd4, 1'b1, 2'd0};
            6'h14, 6'h15, 6'h16, 6'h17: return {4'd5, 1'b1, 2'd0};
            6'h18: return {4'd6, 1'b1, 2'd0};
            6'h19: return {4'd7, 1'b1, 2'd0};
            6'h1A: return {4'd8, 1'b0, 2'd0};
            6'h1B: return {4'd9, 1'b0, 2'd0};
            6'h1C: return {4'd0, 1'b0, 2'd1};
            6'h1D: return {4'd2, 1'b0, 2'd0};
            6'h1E: return {4'd0, 1'b0, 2'd2};
            6'h20: return {4'd10, 1'b1, 2'd0};
            6'h21: return {4'd11, 1'b1, 2'd0};
            6'h22: return {4'd12, 1'b1, 2'd0};
            6'h23: return {4'd13, 1'b1, 2'd0};
            6'h28, 6'h29, 6'h2A, 6'h2B: return {4'd3, 1'b0, 2'd0};
            6'h2D: return {4'd0, 1'b0, 2'd1};
            6'h2E, 6'h2F: return {4'd2, 1'b0, 2'd0};
            6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h36, 6'h37,
            6'h38, 6'h39, 6'h3A, 6'h3B: return {4'd0, 1'b0, 2'd1};
            default: return 7'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_int  = 1'b0;
        m_cnt  = 0;
        m_pend = 1'b0;
        m_out  = '0;
    endtask

    // One clock: update the model from the current inputs, push, clock, pop and compare.
    task automatic tick(input string tag);
        logic [9:0] e;
        logic [9:0] got;
        #1;
        check_val({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!bus.stall && !m_int));
        if (!bus.stall) begin
            if (!m_int) begin
                if (bus.in_valid && !bus.flush)
                    m_out = {1'b1, ref_dec(bus.op_code, bus.ra), 1'b0};
                else
                    m_out = '0;
                if (m_pend || bus.int_req) begin
                    m_int  = 1'b1;
                    m_cnt  = IntCycles - 1;
                    m_pend = m_pend && bus.int_req;
                end
            end else begin
                m_out  = {1'b1, 4'd0, 1'b0, 2'd1, (m_cnt == 0)};
                m_pend = m_pend || bus.int_req;
                if (m_cnt == 0) m_int = 1'b0;
                else            m_cnt--;
            end
        end else begin
            m_pend = m_pend || bus.int_req;
        end
        exp_q.push_back({m_out, m_int});
        @(posedge clk);
        #1;
        got = {bus.out_valid, bus.ALU_CONTROL, bus.SE2, bus.SE3, bus.int_ack, bus.int_busy};
        if (bus.int_ack) ack_seen++;
        e = exp_q.pop_front();
        check_val(tag, 32'(got), 32'(e));
    endtask

    task automatic drive(input string tag, input logic v, input logic [3:0] op,
                         input logic [1:0] r, input logic ir, input logic st, input logic fl);
        bus.in_valid = v;
        bus.op_code  = op;
        bus.ra       = r;
        bus.rb       = ~r;
        bus.int_req  = ir;
        bus.stall    = st;
        bus.flush    = fl;
        tick(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) drive(tag, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op_code  = '0;
        bus.ra       = '0;
        bus.rb       = '0;
        bus.int_req  = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        model_reset();
        #12;
        check_val("reset_outputs",
                  32'({bus.out_valid, bus.ALU_CONTROL, bus.SE2, bus.SE3, bus.int_ack, bus.int_busy}),
                  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full decode sweep, including NOP opcodes 0x0, 0x9, 0xF.
        for (int op = 0; op < 16; op++)
            for (int r = 0; r < 4; r++)
                drive("decode", 1'b1, 4'(op), 2'(r), 1'b0, 1'b0, 1'b0);
        idle("decode_tail", 1);

        // ADD then three stalled cycles with a different word offered.
        drive("stall_add", 1'b1, 4'h2, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive("stall_hold", 1'b1, 4'h5, 2'd1, 1'b0, 1'b1, 1'b0);
        idle("stall_tail", 2);

        // Interrupt with ADD; the ADD word comes first, then the forced words.
        ack_seen = 0;
        drive("int_add", 1'b1, 4'h2, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive("int_seq", 1'b1, 4'h3, 2'd0, 1'b0, 1'b0, 1'b0);
        idle("int_tail", 2);
        check_val("int_ack_count1", 32'(ack_seen), 32'd1);

        // Second request while busy: re-entry after one RUN cycle.
        ack_seen = 0;
        drive("int2_req", 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        drive("int2_again", 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        drive("int2_stall", 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle("int2_run", 8);
        check_val("int_ack_count2", 32'(ack_seen), 32'd2);

        // Flush drops a MOV; flush during the sequence changes nothing.
        drive("flush_mov", 1'b1, 4'h7, 2'd0, 1'b0, 1'b0, 1'b1);
        drive("flush_next", 1'b1, 4'h7, 2'd2, 1'b0, 1'b0, 1'b0);
        drive("flush_int", 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b1);
        drive("flush_seq", 1'b1, 4'h1, 2'd0, 1'b0, 1'b0, 1'b1);
        drive("flush_seq", 1'b1, 4'h1, 2'd0, 1'b0, 1'b0, 1'b1);
        idle("flush_tail", 2);

        // Reset mid-sequence with another request pending.
        ack_seen = 0;
        drive("rst_int", 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        bus.int_req = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check_val("rst_async",
                  32'({bus.out_valid, bus.ALU_CONTROL, bus.SE2, bus.SE3, bus.int_ack, bus.int_busy}),
                  32'd0);
        bus.int_req = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle("rst_after", 5);
        check_val("rst_no_ack", 32'(ack_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
